bsg_flow_credit_rr_arb: RTL and testbench
=========================================

// Module: bsg_flow_credit_rr_arb
// PURPOSE
//  Shares one credit-flow-controlled downstream channel among els_p valid/yumi requesters.
//  Grants one requester per cycle, round-robin, only while downstream credits remain.
//  Counts credits locally: each send consumes one, each fc_i pulse returns one.
//  Sits upstream of the flow-convert stage; v_o/fc_i connect directly to that stage's per-channel bits.
// PARAMETERS
//  els_p        4   number of requesters (>=1)
//  credits_p    8   downstream buffer depth = initial credit count (>=1)
//  lg_credits_lp    $clog2(credits_p+1), width of credit counter (derived, not overridable)
//  lg_els_lp        max(1,$clog2(els_p)), width of grant id (derived)
// PORTS
//  clk_i            in   1           clock, all state on rising edge
//  reset_n_i        in   1           synchronous reset, active low
//  v_i              in   els_p       per-requester valid
//  yumi_o           out  els_p       one-hot (or zero) accept; requester drops/advances data same cycle
//  v_o              out  1           send pulse to downstream channel, consumes one credit
//  grant_id_o       out  lg_els_lp   index of granted requester, valid when v_o=1 (for data mux select)
//  fc_i             in   1           credit-return pulse from downstream, one credit per cycle high
//  credits_o        out  lg_credits_lp  current credit count (pre-update value)
//  overflow_o       out  1           sticky error: credit returned while counter already credits_p
// BEHAVIOUR
//  - Reset (reset_n_i=0 at rising edge): credits_r<=credits_p, rr pointer<=0, overflow_r<=0.
//    While reset_n_i=0: yumi_o=0, v_o=0; grant_id_o=0; credits_o shows the register.
//  - Grant is combinational, zero latency: v_o = (|v_i) & (credits_r!=0); yumi_o[grant_id_o]=v_o.
//  - Round-robin: search starts at ptr_r, wraps modulo els_p; first set v_i wins.
//    On v_o=1: ptr_r <= grant_id_o+1, wrapping to 0 at els_p (non-power-of-2 els_p handled explicitly).
//    No grant -> ptr_r holds. Single active requester is granted every cycle while credits last.
//  - Credit update each cycle: credits_r <= credits_r - v_o + fc_i.
//    Simultaneous send and return: count unchanged.
//    credits_r==0: no grant even if fc_i=1 this cycle (return usable next cycle; no comb fc_i->v_o path).
//    credits_r==credits_p and fc_i=1 and v_o=0: count saturates at credits_p, overflow_r<=1 (sticky until reset).
//    credits_r==credits_p, fc_i=1, v_o=1: legal, count stays credits_p, no overflow.
//  - No state machine beyond counter + pointer; underflow impossible by construction.
//  - Reset mid-operation: in-flight credits are forgotten; downstream must be reset in the same cycle.
//  - v_i may drop without a grant; no fairness memory besides ptr_r.
// STRUCTURE
//  - Shared package bsg_flow_pkg: no typedefs needed; widths derived locally via $clog2.
//  - One sub-module: bsg_flow_rr_pick (els_p): inputs req vector + ptr, outputs found, one-hot, id.
//    Implemented as doubled-vector priority scan; purely combinational.
//  - Top level: credit counter register, pointer register, overflow flag, output gating.
// TESTING
//  1 Reset: after reset_n_i low 2 cycles -> credits_o=8, v_o=0, yumi_o=0, overflow_o=0.
//  2 els_p=4, v_i=4'b1111 held, fc_i=0 -> grants ids 0,1,2,3,0,1,2,3 then v_o=0 from cycle 9, credits_o=0.
//  3 credits 0, fc_i pulse one cycle, v_i=4'b0100 -> next cycle v_o=1, yumi_o=4'b0100, then stall.
//  4 credits_o=3, v_i=4'b0001 and fc_i=1 both held 10 cycles -> v_o=1 each cycle, credits_o stays 3.
//  5 Idle at credits_o=8, fc_i=1 one cycle -> overflow_o=1, credits_o=8, overflow_o persists until reset.
//  6 els_p=3, v_i=3'b101, ptr after grant id2 -> next grant id0 (wrap), then id2; reset asserted mid-burst
//    -> next cycle credits_o=credits_p, ptr=0, yumi_o=0.

Source files
------------

// File: rtl/bsg_flow_pkg.sv
// Shared helpers for the credit-flow arbiter slice.
package bsg_flow_pkg;

  localparam int default_els_lp     = 4;
  localparam int default_credits_lp = 8;

  // Index width that never collapses to zero for a single element.
  function automatic int lg_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_flow_credit_rr_arb_if.sv
// Requester/downstream bundle seen by the credit round-robin arbiter.
interface bsg_flow_credit_rr_arb_if
  import bsg_flow_pkg::*;
#(
  parameter int els_p     = default_els_lp,
  parameter int credits_p = default_credits_lp
) ();

  localparam int lg_els_lp     = lg_min1(els_p);
  localparam int lg_credits_lp = $clog2(credits_p + 1);

  logic [els_p-1:0]         v_i;
  logic [els_p-1:0]         yumi_o;
  logic                     v_o;
  logic [lg_els_lp-1:0]     grant_id_o;
  logic                     fc_i;
  logic [lg_credits_lp-1:0] credits_o;
  logic                     overflow_o;

  modport master (
    output v_i, fc_i,
    input  yumi_o, v_o, grant_id_o, credits_o, overflow_o
  );

  modport slave (
    input  v_i, fc_i,
    output yumi_o, v_o, grant_id_o, credits_o, overflow_o
  );

endinterface

// File: rtl/bsg_flow_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo els_p.
// Purely combinational scan over a doubled request vector.
module bsg_flow_rr_pick
  import bsg_flow_pkg::*;
#(
  parameter int els_p     = 4,
  parameter int lg_els_lp = lg_min1(els_p)
) (
  input  logic [els_p-1:0]     req,
  input  logic [lg_els_lp-1:0] ptr,
  output logic                 found,
  output logic [els_p-1:0]     one_hot,
  output logic [lg_els_lp-1:0] id
);

  logic [2*els_p-1:0] req2;
  int                 s;

  assign req2 = {req, req};

  always_comb begin
    found   = 1'b0;
    one_hot = '0;
    id      = '0;
    s       = 0;
    for (int i = 0; i < els_p; i++) begin
      if (!found && req2[int'(ptr) + i]) begin
        found = 1'b1;
        s     = int'(ptr) + i;
        if (s >= els_p) s = s - els_p;
        one_hot[s] = 1'b1;
        id         = lg_els_lp'(s);
      end
    end
  end

endmodule

// File: rtl/bsg_flow_credit_rr_arb.sv
// Round-robin arbiter sharing one credit-flow channel; zero-latency grant gated by
// a local credit counter, pointer advances past each winner, sticky overflow flag.
module bsg_flow_credit_rr_arb
  import bsg_flow_pkg::*;
#(
  parameter int els_p     = 4,
  parameter int credits_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  bsg_flow_credit_rr_arb_if.slave  io
);

  localparam int lg_els_lp     = lg_min1(els_p);
  localparam int lg_credits_lp = $clog2(credits_p + 1);

  localparam logic [lg_credits_lp-1:0] credits_max_lp = lg_credits_lp'(credits_p);
  localparam logic [lg_credits_lp-1:0] credit_one_lp  = lg_credits_lp'(1);
  localparam logic [lg_els_lp-1:0]     last_id_lp     = lg_els_lp'(els_p - 1);
  localparam logic [lg_els_lp-1:0]     id_one_lp      = lg_els_lp'(1);

  logic [lg_els_lp-1:0]     ptr_r;
  logic [lg_els_lp-1:0]     pick_id;
  logic [els_p-1:0]         pick_oh;
  logic                     found;
  logic                     send;
  logic [lg_credits_lp-1:0] credits_r;
  logic                     overflow_r;

  bsg_flow_rr_pick #(.els_p(els_p), .lg_els_lp(lg_els_lp)) pick (
    .req     (io.v_i),
    .ptr     (ptr_r),
    .found   (found),
    .one_hot (pick_oh),
    .id      (pick_id)
  );

  // A credit returned this cycle only becomes spendable next cycle.
  assign send = reset_n_i & found & (credits_r != '0);

  assign io.v_o        = send;
  assign io.yumi_o     = send ? pick_oh : '0;
  assign io.grant_id_o = send ? pick_id : '0;
  assign io.credits_o  = credits_r;
  assign io.overflow_o = overflow_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      credits_r  <= credits_max_lp;
      ptr_r      <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (send) ptr_r <= (pick_id == last_id_lp) ? '0 : pick_id + id_one_lp;

      case ({send, io.fc_i})
        2'b10: credits_r <= credits_r - credit_one_lp;
        2'b01: begin
          if (credits_r == credits_max_lp) overflow_r <= 1'b1;
          else                             credits_r  <= credits_r + credit_one_lp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_flow_credit_rr_arb.sv
// Directed bench: 4-requester/8-credit and 3-requester/8-credit instances.
module tb_bsg_flow_credit_rr_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  bsg_flow_credit_rr_arb_if #(.els_p(4), .credits_p(8)) a ();
  bsg_flow_credit_rr_arb_if #(.els_p(3), .credits_p(8)) b ();

  bsg_flow_credit_rr_arb #(.els_p(4), .credits_p(8)) dut_a (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .io        (a.slave)
  );

  bsg_flow_credit_rr_arb #(.els_p(3), .credits_p(8)) dut_b (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .io        (b.slave)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n  = 1'b0;
    a.v_i  = 4'b1111;
    a.fc_i = 1'b0;
    b.v_i  = 3'b000;
    b.fc_i = 1'b0;

    // Reset: outputs gated while low, register values after two edges
    settle();
    chk("rst_gate_v", int'(a.v_o), 0);
    chk("rst_gate_yumi", int'(a.yumi_o), 0);
    tick();
    tick();
    settle();
    chk("rst_credits", int'(a.credits_o), 8);
    chk("rst_v", int'(a.v_o), 0);
    chk("rst_yumi", int'(a.yumi_o), 0);
    chk("rst_ovf", int'(a.overflow_o), 0);
    chk("rst_gid", int'(a.grant_id_o), 0);
    rst_n = 1'b1;

    // All four requesting, no returns: 8 grants in rotation then dry
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("rr_v", int'(a.v_o), 1);
      chk("rr_id", int'(a.grant_id_o), k % 4);
      chk("rr_yumi", int'(a.yumi_o), 1 << (k % 4));
      chk("rr_credits", int'(a.credits_o), 8 - k);
      tick();
    end
    settle();
    chk("dry_v", int'(a.v_o), 0);
    chk("dry_yumi", int'(a.yumi_o), 0);
    chk("dry_credits", int'(a.credits_o), 0);

    // Zero credits: a return is not usable in the same cycle
    a.v_i  = 4'b0100;
    a.fc_i = 1'b1;
    settle();
    chk("zc_same_cycle_v", int'(a.v_o), 0);
    tick();
    a.fc_i = 1'b0;
    settle();
    chk("zc_next_v", int'(a.v_o), 1);
    chk("zc_next_yumi", int'(a.yumi_o), 4);
    chk("zc_next_credits", int'(a.credits_o), 1);
    tick();
    settle();
    chk("zc_stall_v", int'(a.v_o), 0);
    chk("zc_stall_credits", int'(a.credits_o), 0);

    // Refill to 3, then send and return together for 10 cycles
    a.v_i  = 4'b0000;
    a.fc_i = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    settle();
    chk("refill3", int'(a.credits_o), 3);
    a.v_i = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("bal_v", int'(a.v_o), 1);
      chk("bal_yumi", int'(a.yumi_o), 1);
      chk("bal_credits", int'(a.credits_o), 3);
      tick();
    end

    // Fill to full, then send+return at full is legal
    a.v_i = 4'b0000;
    for (int k = 0; k < 5; k++) tick();
    settle();
    chk("full_credits", int'(a.credits_o), 8);
    chk("full_ovf", int'(a.overflow_o), 0);
    a.v_i = 4'b0001;
    tick();
    settle();
    chk("full_bal_credits", int'(a.credits_o), 8);
    chk("full_bal_ovf", int'(a.overflow_o), 0);

    // Idle return at full: saturate and flag
    a.v_i = 4'b0000;
    tick();
    a.fc_i = 1'b0;
    settle();
    chk("ovf_set", int'(a.overflow_o), 1);
    chk("ovf_credits", int'(a.credits_o), 8);
    for (int k = 0; k < 3; k++) tick();
    settle();
    chk("ovf_sticky", int'(a.overflow_o), 1);

    // Reset clears overflow; then run the 3-requester instance
    rst_n = 1'b0;
    tick();
    settle();
    chk("ovf_cleared", int'(a.overflow_o), 0);
    rst_n = 1'b1;

    b.v_i = 3'b111;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("b_rr_id", int'(b.grant_id_o), k % 3);
      chk("b_rr_yumi", int'(b.yumi_o), 1 << (k % 3));
      tick();
    end
    b.v_i = 3'b101;
    settle();
    chk("b_skip_id", int'(b.grant_id_o), 2);
    tick();
    settle();
    chk("b_wrap_id", int'(b.grant_id_o), 0);
    chk("b_wrap_yumi", int'(b.yumi_o), 1);
    tick();
    settle();
    chk("b_credits", int'(b.credits_o), 2);

    // Reset mid-burst (pointer currently 1)
    rst_n = 1'b0;
    settle();
    chk("b_rst_yumi", int'(b.yumi_o), 0);
    chk("b_rst_v", int'(b.v_o), 0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("b_post_credits", int'(b.credits_o), 8);
    chk("b_post_id", int'(b.grant_id_o), 0);
    chk("b_post_yumi", int'(b.yumi_o), 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
